// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - EX-to-MEM pipeline bus; perf outputs exist only with EX_MEM_PERF_CNT_EN
interface ex_mem_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      stall;
    logic                      flush;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic                      alu_zero;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
    logic                      branch;
    logic                      branch_ne;
    logic [DATA_WIDTH-1:0]     branch_target;

    logic                      valid_o;
    logic [DATA_WIDTH-1:0]     result_o;
    logic [DATA_WIDTH-1:0]     store_data_o;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_o;
    logic                      reg_write_o;
    logic                      mem_read_o;
    logic                      mem_write_o;
    logic                      mem_to_reg_o;
    logic                      misaligned_o;
    logic                      redirect_o;
    logic [DATA_WIDTH-1:0]     redirect_pc_o;
`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0]               perf_instr_cnt;
    logic [31:0]               perf_taken_cnt;
`endif

    modport master (
        output in_valid, stall, flush, alu_result, alu_zero, store_data, rd_addr,
               reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne, branch_target,
        input  valid_o, result_o, store_data_o, rd_addr_o, reg_write_o, mem_read_o,
               mem_write_o, mem_to_reg_o, misaligned_o, redirect_o, redirect_pc_o
`ifdef EX_MEM_PERF_CNT_EN
        , input perf_instr_cnt, perf_taken_cnt
`endif
    );

    modport slave (
        input  in_valid, stall, flush, alu_result, alu_zero, store_data, rd_addr,
               reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne, branch_target,
        output valid_o, result_o, store_data_o, rd_addr_o, reg_write_o, mem_read_o,
               mem_write_o, mem_to_reg_o, misaligned_o, redirect_o, redirect_pc_o
`ifdef EX_MEM_PERF_CNT_EN
        , output perf_instr_cnt, perf_taken_cnt
`endif
    );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with branch redirect; EX_MEM_PERF_CNT_EN adds perf counters
module ex_mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst,
    ex_mem_stage_if.slave  bus
);
    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     result_q;
    logic [DATA_WIDTH-1:0]     store_data_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
    logic                      reg_write_q;
    logic                      mem_read_q;
    logic                      mem_write_q;
    logic                      mem_to_reg_q;
    logic                      taken_q;
    logic                      issued_q;
    logic [DATA_WIDTH-1:0]     redirect_pc_q;

    logic                      misaligned;
    logic                      redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            result_q      <= '0;
            store_data_q  <= '0;
            rd_addr_q     <= '0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            taken_q       <= 1'b0;
            issued_q      <= 1'b0;
            redirect_pc_q <= '0;
        end else if (bus.flush) begin
            valid_q       <= 1'b0;
            result_q      <= '0;
            store_data_q  <= '0;
            rd_addr_q     <= '0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            taken_q       <= 1'b0;
            issued_q      <= 1'b0;
            redirect_pc_q <= '0;
        end else if (bus.stall) begin
            // A stalled taken branch must redirect fetch only once.
            issued_q <= issued_q | redirect;
        end else begin
            valid_q       <= bus.in_valid;
            result_q      <= bus.alu_result;
            store_data_q  <= bus.store_data;
            rd_addr_q     <= bus.rd_addr;
            reg_write_q   <= bus.reg_write;
            mem_read_q    <= bus.mem_read;
            mem_write_q   <= bus.mem_write;
            mem_to_reg_q  <= bus.mem_to_reg;
            taken_q       <= bus.in_valid & bus.branch & (bus.alu_zero ^ bus.branch_ne);
            issued_q      <= 1'b0;
            redirect_pc_q <= bus.branch_target;
        end
    end

    // Misalignment is judged on the stored enables so it can suppress them without a loop.
    assign misaligned = valid_q & (mem_read_q | mem_write_q) & (result_q[1:0] != 2'b00);
    assign redirect   = taken_q & ~issued_q;

    assign bus.valid_o       = valid_q;
    assign bus.result_o      = result_q;
    assign bus.store_data_o  = store_data_q;
    assign bus.rd_addr_o     = rd_addr_q;
    assign bus.reg_write_o   = reg_write_q  & valid_q & ~misaligned;
    assign bus.mem_read_o    = mem_read_q   & valid_q & ~misaligned;
    assign bus.mem_write_o   = mem_write_q  & valid_q & ~misaligned;
    assign bus.mem_to_reg_o  = mem_to_reg_q & valid_q;
    assign bus.misaligned_o  = misaligned;
    assign bus.redirect_o    = redirect;
    assign bus.redirect_pc_o = redirect_pc_q;

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] instr_cnt_q;
    logic [31:0] taken_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else begin
            if (!bus.flush && !bus.stall && bus.in_valid && (instr_cnt_q != 32'hFFFF_FFFF))
                instr_cnt_q <= instr_cnt_q + 32'd1;
            if (redirect && (taken_cnt_q != 32'hFFFF_FFFF))
                taken_cnt_q <= taken_cnt_q + 32'd1;
        end
    end

    assign bus.perf_instr_cnt = instr_cnt_q;
    assign bus.perf_taken_cnt = taken_cnt_q;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_mem_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    ex_mem_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        mis;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t observe();
        exp_t o;
        o.valid  = bus.valid_o;
        o.result = bus.result_o;
        o.sdata  = bus.store_data_o;
        o.rd     = bus.rd_addr_o;
        o.rw     = bus.reg_write_o;
        o.mr     = bus.mem_read_o;
        o.mw     = bus.mem_write_o;
        o.m2r    = bus.mem_to_reg_o;
        o.mis    = bus.misaligned_o;
        o.redir  = bus.redirect_o;
        o.rpc    = bus.redirect_pc_o;
        return o;
    endfunction

    task automatic idle_inputs();
        bus.in_valid = 0; bus.stall = 0; bus.flush = 0;
        bus.alu_result = '0; bus.alu_zero = 0; bus.store_data = '0; bus.rd_addr = '0;
        bus.reg_write = 0; bus.mem_read = 0; bus.mem_write = 0; bus.mem_to_reg = 0;
        bus.branch = 0; bus.branch_ne = 0; bus.branch_target = '0;
    endtask

    // Drive one EX instruction and push what the MEM side must show after the edge.
    task automatic drive(input logic v, input logic [31:0] res, input logic zero,
                         input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic m2r,
                         input logic br, input logic bne, input logic [31:0] tgt);
        exp_t e;
        bus.in_valid = v; bus.stall = 0; bus.flush = 0;
        bus.alu_result = res; bus.alu_zero = zero; bus.store_data = sd; bus.rd_addr = rd;
        bus.reg_write = rw; bus.mem_read = mr; bus.mem_write = mw; bus.mem_to_reg = m2r;
        bus.branch = br; bus.branch_ne = bne; bus.branch_target = tgt;
        e.valid  = v;
        e.result = res;
        e.sdata  = sd;
        e.rd     = rd;
        e.mis    = v & (mr | mw) & (res[1:0] != 2'b00);
        e.rw     = v & rw & ~e.mis;
        e.mr     = v & mr & ~e.mis;
        e.mw     = v & mw & ~e.mis;
        e.m2r    = v & m2r;
        e.redir  = v & br & (zero ^ bne);
        e.rpc    = tgt;
        last = e;
        q.push_back(e);
    endtask

    task automatic push_stall();
        exp_t e;
        e = last;
        e.redir = 1'b0;
        last = e;
        q.push_back(e);
        bus.stall = 1; bus.flush = 0;
    endtask

    task automatic push_flush(input logic with_stall);
        last = '0;
        q.push_back('0);
        bus.stall = with_stall; bus.flush = 1;
    endtask

    task automatic tick_check(input string name);
        exp_t e;
        exp_t o;
        @(posedge clk);
        #1;
        o = observe();
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, o);
        end else begin
            e = q.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", name, o, e);
            end
        end
        bus.stall = 0; bus.flush = 0;
    endtask

    task automatic test_reset();
        exp_t o;
        idle_inputs();
        rst = 1;
        #12;
        o = observe();
        n_checks++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", o);
        end
        @(negedge clk);
        rst = 0;
        last = '0;
    endtask

    task automatic test_load();
        drive(1, 32'h10, 0, 32'hAAAA_5555, 5'd5, 1, 0, 0, 0, 0, 0, 32'h0);
        tick_check("load");
    endtask

    task automatic test_branch_stall();
        drive(1, 32'h0, 1, 32'h0, 5'd0, 0, 0, 0, 0, 1, 0, 32'h40);
        tick_check("beq_taken_first");
        for (int i = 0; i < 3; i++) begin
            push_stall();
            tick_check("beq_stall_no_repeat");
        end
        drive(1, 32'h0, 1, 32'h0, 5'd0, 0, 0, 0, 0, 1, 1, 32'h80);
        tick_check("bne_zero_not_taken");
        drive(1, 32'h5, 0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 1, 32'hC0);
        tick_check("bne_nonzero_taken");
    endtask

    task automatic test_flush_stall();
        drive(1, 32'h100, 0, 32'hDEAD_BEEF, 5'd0, 0, 0, 1, 0, 0, 0, 32'h0);
        tick_check("store_loaded");
        push_flush(1);
        tick_check("flush_over_stall");
        drive(1, 32'h0, 1, 32'h0, 5'd0, 0, 0, 0, 0, 1, 0, 32'h44);
        tick_check("beq_before_flush");
        push_flush(0);
        tick_check("flush_kills_redirect");
    endtask

    task automatic test_misaligned();
        drive(1, 32'h6, 0, 32'h1234, 5'd0, 0, 0, 1, 0, 0, 0, 32'h0);
        tick_check("misaligned_store");
        drive(1, 32'h8, 0, 32'h1234, 5'd0, 0, 0, 1, 0, 0, 0, 32'h0);
        tick_check("aligned_store");
        drive(1, 32'h3, 0, 32'h0, 5'd9, 1, 1, 0, 1, 0, 0, 32'h0);
        tick_check("misaligned_load_no_wb");
        drive(0, 32'h3, 1, 32'h0, 5'd9, 1, 1, 1, 1, 1, 0, 32'h50);
        tick_check("bubble_inert");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [31:0] r;
            r = $urandom;
            drive(1'($urandom_range(0, 3) != 0), {r[31:2], 2'($urandom_range(0, 3))},
                  1'($urandom), $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            tick_check("back_to_back");
        end
    endtask

    task automatic test_reset_midrun();
        exp_t o;
        drive(1, 32'h20, 0, 32'h0, 5'd3, 1, 0, 0, 0, 1, 0, 32'h60);
        bus.alu_zero = 1;
        last.redir = 1'b1;
        q[q.size()-1] = last;
        tick_check("pre_reset_load");
        #3;
        rst = 1;
        #1;
        o = observe();
        n_checks++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL reset_midrun_async: got %h expected 0", o);
        end
        idle_inputs();
        @(negedge clk);
        rst = 0;
        last = '0;
    endtask

`ifdef EX_MEM_PERF_CNT_EN
    task automatic test_perf();
        rst = 1;
        @(negedge clk);
        rst = 0;
        last = '0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h4 * i, (i == 2 || i == 7), 32'h0, 5'd1, 1, 0, 0, 0,
                  (i == 2 || i == 7), 0, 32'h200 + i);
            tick_check("perf_load");
            if (i == 2 || i == 4 || i == 7) begin
                push_stall();
                tick_check("perf_stall");
            end
        end
        push_flush(0);
        bus.in_valid = 1;
        tick_check("perf_flush");
        n_checks++;
        if (bus.perf_instr_cnt !== 32'd10) begin
            n_fail++;
            $display("FAIL perf_instr_cnt: got %0d expected 10", bus.perf_instr_cnt);
        end
        n_checks++;
        if (bus.perf_taken_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_taken_cnt: got %0d expected 2", bus.perf_taken_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_branch_stall();
        test_flush_stall();
        test_misaligned();
        test_back_to_back();
        test_reset_midrun();
`ifdef EX_MEM_PERF_CNT_EN
        test_perf();
`endif
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
